// File: rtl/blackjack_pkg.sv
// Shared constants for the blackjack front end: button indices and 25 MHz debounce defaults.
package blackjack_pkg;

  localparam int unsigned BTN_HIT    = 0;
  localparam int unsigned BTN_STAND  = 1;
  localparam int unsigned BTN_DOUBLE = 2;
  localparam int unsigned BTN_START  = 3;

  localparam int unsigned NUM_BTN_DEF     = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned TICK_DIV_DEF    = 25000;  // 1 ms at 25 MHz
  localparam int unsigned DEB_TICKS_DEF   = 10;

  // ui_in bit feeding each button index (hit, stand, double, start)
  localparam int unsigned UI_BTN_BIT [NUM_BTN_DEF] = '{0, 1, 2, 4};

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw ui pins and the game core.
// Optional press_count field is present when BTN_EVENT_COUNT_EN is defined.
interface button_conditioner_if #(
  parameter int unsigned NUM_BTN = 4
);
  logic [NUM_BTN-1:0]   btn_raw;
  logic [NUM_BTN-1:0]   btn_level;
  logic [NUM_BTN-1:0]   btn_press;
  logic [NUM_BTN-1:0]   btn_release;
  logic                 press_conflict;
`ifdef BTN_EVENT_COUNT_EN
  logic [NUM_BTN*8-1:0] press_count;
`endif

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, press_conflict
`ifdef BTN_EVENT_COUNT_EN
    , input press_count
`endif
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, press_conflict
`ifdef BTN_EVENT_COUNT_EN
    , output press_count
`endif
  );
endinterface

// File: rtl/button_conditioner_ch.sv
// One button channel: synchronizer, tick-based stability counter, level and edge pulses.
// With BTN_EVENT_COUNT_EN defined, also keeps a saturating 8-bit press counter.
module btn_debounce_ch #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_TICKS   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw,
  input  logic       tick,
  output logic       level,
  output logic       press,
  output logic       rel,
  output logic       press_nxt
`ifdef BTN_EVENT_COUNT_EN
  , output logic [7:0] press_count
`endif
);
  localparam int unsigned CntW = $clog2(DEB_TICKS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Any agreement between sync and level restarts the count, tick or not.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (sync == level_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CntLast) begin
        level_d = ~level_q;
        cnt_d   = '0;
        press_d = ~level_q;
        rel_d   = level_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign rel       = rel_q;
  assign press_nxt = press_d;

`ifdef BTN_EVENT_COUNT_EN
  logic [7:0] pcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= 8'd0;
    end else if (press_d && (pcnt_q != 8'hff)) begin
      pcnt_q <= pcnt_q + 8'd1;
    end
  end

  assign press_count = pcnt_q;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Debounces the player buttons: shared tick prescaler, per-button channels, conflict flag.
// Define BTN_EVENT_COUNT_EN to add per-button saturating press counters.
module button_conditioner
  import blackjack_pkg::*;
#(
  parameter int unsigned NUM_BTN     = NUM_BTN_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
  parameter int unsigned DEB_TICKS   = DEB_TICKS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.slave  bus
);
  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

  logic [DivW-1:0]    div_q;
  logic               tick;
  logic [NUM_BTN-1:0] level, press, rel, press_nxt;
  logic               conflict_q;
`ifdef BTN_EVENT_COUNT_EN
  logic [NUM_BTN*8-1:0] pcount;
`endif

  // With TICK_DIV == 1 the counter stays at 0 and tick is constantly high.
  assign tick = (div_q == DivLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      div_q      <= tick ? '0 : div_q + DivW'(1);
      conflict_q <= ($countones(press_nxt) >= 2);
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_TICKS   (DEB_TICKS)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw         (bus.btn_raw[i]),
      .tick        (tick),
      .level       (level[i]),
      .press       (press[i]),
      .rel         (rel[i]),
      .press_nxt   (press_nxt[i])
`ifdef BTN_EVENT_COUNT_EN
      , .press_count (pcount[i*8 +: 8])
`endif
    );
  end

  assign bus.btn_level      = level;
  assign bus.btn_press      = press;
  assign bus.btn_release    = rel;
  assign bus.press_conflict = conflict_q;
`ifdef BTN_EVENT_COUNT_EN
  assign bus.press_count    = pcount;
`endif

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream stage of blackjack_core. Turns the raw player buttons (hit, stand, double, start) into clean, debounced levels and single-cycle press/release pulses on the core clock.
- Contains a synchronizer chain, a shared debounce prescaler and per-button stability counters.
- The top-level wrapper routes its ui_in buttons through this block before they reach the game core.

Parameters:
- NUM_BTN, 4, number of button channels; index 0=hit, 1=stand, 2=double, 3=start.
- SYNC_STAGES, 2, flops in each input synchronizer; must be at least 2.
- TICK_DIV, 25000, clk cycles per debounce tick (1 ms at 25 MHz); must be at least 1.
- DEB_TICKS, 10, consecutive mismatching ticks needed to accept a new level; must be at least 1.

Ports:
- clk, input, 1, core clock.
- rst_n, input, 1, asynchronous active-low reset.
- btn_raw, input, NUM_BTN, asynchronous raw button levels, active-high.
- btn_level, output, NUM_BTN, debounced level per button.
- btn_press, output, NUM_BTN, one-cycle pulse on each debounced 0->1 transition.
- btn_release, output, NUM_BTN, one-cycle pulse on each debounced 1->0 transition.
- press_conflict, output, 1, one-cycle pulse when two or more bits of btn_press assert in the same cycle.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all synchronizer flops, the prescaler, every counter and every output are 0.
- Synchronizer: btn_raw passes through SYNC_STAGES flops; the last stage is sync[i].
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is high for exactly the cycle in which the count equals TICK_DIV-1.
  - With TICK_DIV=1, tick is high every cycle.
- Per-channel state is {level, cnt}; cnt is $clog2(DEB_TICKS+1) bits wide.
- Per-channel update, evaluated every clk edge:
  - If sync[i]==level: cnt <= 0 (immediately, tick or not).
  - Else if tick and cnt==DEB_TICKS-1: level <= ~level and cnt <= 0. In the same edge, btn_press[i] <= ~level (the old level) and btn_release[i] <= level (the old level).
  - Else if tick: cnt <= cnt+1.
  - Else: hold.
- Pulse outputs are registered and high for exactly one cycle; they are 0 in every cycle without a transition.
- Latency from a clean raw edge to the pulse: SYNC_STAGES cycles plus the wait until the DEB_TICKS-th tick that sees the mismatch. Total is between SYNC_STAGES+(DEB_TICKS-1)*TICK_DIV+1 and SYNC_STAGES+DEB_TICKS*TICK_DIV cycles.
- Glitch rejection: any return of sync to level before acceptance clears cnt. Bouncing therefore restarts the count and produces no event.
- Channels are fully independent; simultaneous presses all pulse.
- press_conflict is registered alongside btn_press: it is high when popcount of the next btn_press value is at least 2.
- A button held through reset release reads as level 0. After debounce it produces a btn_press, so a held button counts as a press.
- Reset asserted mid-count discards the pending transition and any in-flight pulse.
- btn_level changes only at accept edges and never toggles more than once per DEB_TICKS ticks.

Optional Feature:
- Macro: BTN_EVENT_COUNT_EN.
- When defined:
  - Adds output press_count, NUM_BTN*8 bits; byte i holds the press count of button i.
  - Each byte is 8 bits, saturates at 255, resets to 0, and increments on the same edge that raises btn_press[i].
- When not defined, the port and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package blackjack_pkg holds:
  - Button index constants BTN_HIT=0, BTN_STAND=1, BTN_DOUBLE=2, BTN_START=3.
  - Default debounce constants for the 25 MHz clock.
- The top level maps ui_in bits {4,2,1,0} to indices {3,2,1,0}.
- Sub-module btn_debounce_ch implements one channel (synchronizer, counter, level, pulses, optional press counter). It is instantiated NUM_BTN times.
- The prescaler and conflict detector live in the parent.

Test Plan:
All scenarios use TICK_DIV=4, DEB_TICKS=3, SYNC_STAGES=2.
- Clean press: btn_raw[0] rises and holds. btn_level[0] rises and btn_press[0] pulses for 1 cycle, within 11..14 cycles of the raw edge; btn_release stays 0.
- Bounce: btn_raw[1] toggles high for 6 cycles, low for 2, then high and held. No event during the bounce; exactly one btn_press[1], 11..14 cycles after the final rise.
- Short glitch: btn_raw[2] high for 8 cycles only. btn_level, btn_press and btn_release all stay 0.
- Simultaneous: btn_raw[0] and btn_raw[3] rise on the same cycle. Both btn_press bits pulse on the same cycle and press_conflict pulses once.
- Release and reset: release a held button to get one btn_release. Separately, hold btn_raw[3] across rst_n deassertion: level is 0 right after reset, then one btn_press[3] follows. Asserting rst_n mid-count clears all outputs immediately.
- BTN_EVENT_COUNT_EN: 300 debounced presses on button 0. press_count byte 0 reads 255 and the other bytes read 0.
